idu_issue_sb: RTL and testbench
===============================

IDU_ISSUE_SB -- requirements
Module: idu_issue_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width (counter width).
REQ-002 SHALL have parameter NUNITS, default 4: number of execution units (ALU, MUL, DIV, LSU), minimum 2.
REQ-003 SHALL have parameter PAYLOAD_W, default 256: width of opaque decoded-instruction payload.
REQ-004 SHALL have parameter UW = max(1, clog2(NUNITS)): unit index width.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_flush  in  1  discard the issue register.
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  instruction accepted this cycle.
- dec_rs1_en, dec_rs2_en, dec_rd_en  in  1 each  operand/destination used.
- dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  5 each  register indices.
- dec_unit  in  UW  target execution unit.
- dec_payload  in  PAYLOAD_W  decoded fields, passed through.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  EXU takes the instruction.
- iss_unit  out  UW; iss_rd_en  out  1; iss_rd_addr  out  5; iss_payload  out  PAYLOAD_W.
- unit_busy  in  NUNITS  unit cannot accept a new instruction.
- wb_en  in  NUNITS  per-unit writeback strobe.
- wb_rd_addr  in  5*NUNITS  per-unit writeback index, unit u at bits [5u+4:5u].
- sb_pending  out  32  scoreboard bits, observation only.
- stall_cnt  out  XLEN  cycles decode was stalled.

Function
REQ-006 SHALL keep a 32-bit scoreboard pending[]; pending[0] SHALL always read 0.
REQ-007 pending[r] SHALL be set on the cycle iss_valid & iss_ready & iss_rd_en & iss_rd_addr==r, r!=0.
REQ-008 pending[r] SHALL be cleared on any cycle where some wb_en[u] with wb_rd_addr[u]==r; simultaneous set and clear of the same r SHALL result in set.
REQ-009 A source hazard SHALL exist for rsN when dec_rsN_en and rsN!=0 and (pending[rsN] and no same-cycle writeback to rsN) or (iss_valid & iss_rd_en & iss_rd_addr==rsN).
REQ-010 A WAW hazard SHALL exist under the same condition applied to dec_rd_en/dec_rd_addr.
REQ-011 A structural hazard SHALL exist when unit_busy[dec_unit] is 1; dec_unit >= NUNITS SHALL be treated as busy.
REQ-012 Issue register SHALL be free when iss_valid==0 or iss_ready==1.
REQ-013 dec_ready SHALL equal free & no hazard & ~pipe_flush, combinational.
REQ-014 On dec_valid & dec_ready the issue register SHALL load dec_unit, dec_rd_en, dec_rd_addr, dec_payload and set iss_valid next cycle (latency 1).
REQ-015 When iss_valid & iss_ready and no new accept, iss_valid SHALL clear next cycle; otherwise contents SHALL hold stable while iss_valid & ~iss_ready.
REQ-016 iss_valid SHALL NOT depend combinationally on iss_ready.
REQ-017 pipe_flush SHALL clear iss_valid next cycle, with no scoreboard set for the flushed entry; pending bits of already-issued instructions SHALL be retained.
REQ-018 stall_cnt SHALL increment by 1 each cycle with dec_valid & ~dec_ready & ~pipe_flush and saturate at all-ones.
REQ-019 Multiple wb_en bits in one cycle SHALL all clear their registers.

Reset
REQ-020 rst_n low SHALL asynchronously clear pending, iss_valid, iss_unit, iss_rd_en, iss_rd_addr, iss_payload and stall_cnt to 0.
REQ-021 Reset mid-operation SHALL drop any held instruction; first accept is possible in the first cycle after rst_n rises.

Verification
REQ-022 RAW: issue rd=5 unit 1, accepted by EXU; next dec rs1=5 -> dec_ready=0 until wb_en[1] with wb_rd_addr=5, accepted that same cycle; stall_cnt equals stalled cycles.
REQ-023 In-register RAW: iss holds rd=7, iss_ready=0; dec rs2=7 -> dec_ready=0; iss_ready=1 -> pending[7]=1 next cycle, dec still stalled.
REQ-024 x0: dec rd=0 then rs1=0 back-to-back -> no stall, sb_pending stays 0.
REQ-025 Structural: unit_busy=4'b0100, dec_unit=2 -> dec_ready=0; busy drops -> accept, iss_valid=1 next cycle.
REQ-026 Flush: iss_valid=1 rd=9, pipe_flush=1 with iss_ready=0 -> iss_valid=0, pending[9]=0, dec_ready=0 that cycle.
REQ-027 Set/clear collision: pending[3]=1, wb clears 3 while issue of rd=3 completes -> pending[3]=1.

Source files
------------

// File: rtl/idu_issue_sb.sv
// idu_issue_sb: single-entry issue register guarded by a 32-entry register
// scoreboard. Decode is held off on source (RAW), destination (WAW) and
// execution-unit (structural) hazards; writebacks clear scoreboard bits.
module idu_issue_sb #(
   parameter int XLEN      = 32,
   parameter int NUNITS    = 4,
   parameter int PAYLOAD_W = 256,
   parameter int UW        = ($clog2(NUNITS) > 1) ? $clog2(NUNITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_flush,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic                  dec_rs1_en,
   input  logic                  dec_rs2_en,
   input  logic                  dec_rd_en,
   input  logic [4:0]            dec_rs1_addr,
   input  logic [4:0]            dec_rs2_addr,
   input  logic [4:0]            dec_rd_addr,
   input  logic [UW-1:0]         dec_unit,
   input  logic [PAYLOAD_W-1:0]  dec_payload,
   output logic                  iss_valid,
   input  logic                  iss_ready,
   output logic [UW-1:0]         iss_unit,
   output logic                  iss_rd_en,
   output logic [4:0]            iss_rd_addr,
   output logic [PAYLOAD_W-1:0]  iss_payload,
   input  logic [NUNITS-1:0]     unit_busy,
   input  logic [NUNITS-1:0]     wb_en,
   input  logic [5*NUNITS-1:0]   wb_rd_addr,
   output logic [31:0]           sb_pending,
   output logic [XLEN-1:0]       stall_cnt
);

   logic [31:0]           r_pending;
   logic                  r_iss_valid;
   logic [UW-1:0]         r_iss_unit;
   logic                  r_iss_rd_en;
   logic [4:0]            r_iss_rd_addr;
   logic [PAYLOAD_W-1:0]  r_iss_payload;
   logic [XLEN-1:0]       r_stall_cnt;

   logic [31:0]           w_wb_hit;
   logic [31:0]           w_set_mask;
   logic [31:0]           w_pending_nxt;
   logic                  w_struct_haz;
   logic                  w_rs1_haz;
   logic                  w_rs2_haz;
   logic                  w_rd_haz;
   logic                  w_iss_fire;
   logic                  w_free;
   logic                  w_accept;
   logic                  w_stall;

   // Collect every register being written back this cycle, across all units.
   // NOTE: every always_comb output gets a default before any conditional
   // write, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_wb_hit = '0;
      for (int u = 0; u < NUNITS; u++) begin
         if (wb_en[u]) w_wb_hit[wb_rd_addr[5*u +: 5]] = 1'b1;
      end
   end

   // Structural hazard: the target unit is busy; an index with no unit behind
   // it defaults to busy so it can never be issued.
   always_comb begin
      w_struct_haz = 1'b1;
      for (int u = 0; u < NUNITS; u++) begin
         if (dec_unit == UW'(u)) w_struct_haz = unit_busy[u];
      end
   end

   // A register is hazardous when it is pending without a same-cycle writeback,
   // or when it is the destination of the instruction sitting in the issue
   // register (which has not reached the scoreboard yet).
   assign w_rs1_haz = dec_rs1_en && (dec_rs1_addr != 5'd0) &&
                      ((r_pending[dec_rs1_addr] && !w_wb_hit[dec_rs1_addr]) ||
                       (r_iss_valid && r_iss_rd_en && (r_iss_rd_addr == dec_rs1_addr)));
   assign w_rs2_haz = dec_rs2_en && (dec_rs2_addr != 5'd0) &&
                      ((r_pending[dec_rs2_addr] && !w_wb_hit[dec_rs2_addr]) ||
                       (r_iss_valid && r_iss_rd_en && (r_iss_rd_addr == dec_rs2_addr)));
   assign w_rd_haz  = dec_rd_en && (dec_rd_addr != 5'd0) &&
                      ((r_pending[dec_rd_addr] && !w_wb_hit[dec_rd_addr]) ||
                       (r_iss_valid && r_iss_rd_en && (r_iss_rd_addr == dec_rd_addr)));

   assign w_iss_fire = r_iss_valid && iss_ready;
   assign w_free     = !r_iss_valid || iss_ready;
   assign dec_ready  = w_free && !w_rs1_haz && !w_rs2_haz && !w_rd_haz &&
                       !w_struct_haz && !pipe_flush;
   assign w_accept   = dec_valid && dec_ready;
   assign w_stall    = dec_valid && !dec_ready && !pipe_flush;

   // Mark the destination of an instruction leaving for the EXU; a flushed
   // entry never reaches the scoreboard.
   always_comb begin
      w_set_mask = '0;
      if (w_iss_fire && r_iss_rd_en && !pipe_flush) w_set_mask[r_iss_rd_addr] = 1'b1;
   end

   // Set wins over a same-cycle clear; x0 is never tracked.
   assign w_pending_nxt = ((r_pending & ~w_wb_hit) | w_set_mask) & ~32'd1;

   // Scoreboard state.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_pending_nxt;
   end

   // Issue register: load on accept, drop on flush or hand-off, else hold.
   // The payload is reset as well so a dropped instruction leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iss_valid   <= 1'b0;
         r_iss_unit    <= '0;
         r_iss_rd_en   <= 1'b0;
         r_iss_rd_addr <= '0;
         r_iss_payload <= '0;
      end else if (w_accept) begin
         r_iss_valid   <= 1'b1;
         r_iss_unit    <= dec_unit;
         r_iss_rd_en   <= dec_rd_en;
         r_iss_rd_addr <= dec_rd_addr;
         r_iss_payload <= dec_payload;
      end else if (pipe_flush || w_iss_fire) begin
         r_iss_valid   <= 1'b0;
      end
   end

   // Saturating count of cycles decode was held off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + XLEN'(1);
   end

   assign iss_valid   = r_iss_valid;
   assign iss_unit    = r_iss_unit;
   assign iss_rd_en   = r_iss_rd_en;
   assign iss_rd_addr = r_iss_rd_addr;
   assign iss_payload = r_iss_payload;
   assign sb_pending  = r_pending;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_idu_issue_sb.sv
// Testbench for idu_issue_sb: per-cycle vector table plus hand sequences,
// with a queue of expected issue-register contents.
module tb_idu_issue_sb;

   localparam int XLEN = 4;
   localparam int NU   = 4;
   localparam int UW   = 2;
   localparam int PW   = 256;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           pipe_flush, dec_valid, dec_ready;
   logic           dec_rs1_en, dec_rs2_en, dec_rd_en;
   logic [4:0]     dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
   logic [UW-1:0]  dec_unit;
   logic [PW-1:0]  dec_payload;
   logic           iss_valid, iss_ready, iss_rd_en;
   logic [UW-1:0]  iss_unit;
   logic [4:0]     iss_rd_addr;
   logic [PW-1:0]  iss_payload;
   logic [NU-1:0]  unit_busy, wb_en;
   logic [5*NU-1:0] wb_rd_addr;
   logic [31:0]    sb_pending;
   logic [XLEN-1:0] stall_cnt;

   idu_issue_sb #(.XLEN(XLEN), .NUNITS(NU), .PAYLOAD_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rd_en(dec_rd_en),
      .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
      .dec_unit(dec_unit), .dec_payload(dec_payload),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_unit(iss_unit),
      .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_payload(iss_payload),
      .unit_busy(unit_busy), .wb_en(wb_en), .wb_rd_addr(wb_rd_addr),
      .sb_pending(sb_pending), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v, r1e; logic [4:0] r1; logic r2e; logic [4:0] r2;
      logic rde; logic [4:0] rd; logic [1:0] un; logic ir;
      logic [3:0] busy, wbe; logic [19:0] wba; logic fl;
      logic erdy, eiv; logic [31:0] esb;
   } vec_t;

   typedef struct {
      logic [1:0] un; logic rde; logic [4:0] rd; logic [PW-1:0] pl;
   } iss_t;

   iss_t        sbq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  exp_stall = 4'd0;

   function automatic vec_t mk(input logic v, r1e, input logic [4:0] r1,
                               input logic r2e, input logic [4:0] r2,
                               input logic rde, input logic [4:0] rd,
                               input logic [1:0] un, input logic ir,
                               input logic [3:0] busy, wbe, input logic [19:0] wba,
                               input logic fl, erdy, eiv, input logic [31:0] esb);
      vec_t t;
      t.v = v; t.r1e = r1e; t.r1 = r1; t.r2e = r2e; t.r2 = r2;
      t.rde = rde; t.rd = rd; t.un = un; t.ir = ir; t.busy = busy;
      t.wbe = wbe; t.wba = wba; t.fl = fl; t.erdy = erdy; t.eiv = eiv; t.esb = esb;
      return t;
   endfunction

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      pipe_flush = 0; dec_valid = 0; dec_rs1_en = 0; dec_rs2_en = 0; dec_rd_en = 0;
      dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0; dec_unit = 0;
      dec_payload = '0; iss_ready = 0; unit_busy = 0; wb_en = 0; wb_rd_addr = 0;
   endtask

   // One cycle: drive at posedge+1, sample at posedge+4, then advance.
   task automatic cyc(input vec_t t, input string tag);
      iss_t e;
      dec_valid = t.v; dec_rs1_en = t.r1e; dec_rs1_addr = t.r1;
      dec_rs2_en = t.r2e; dec_rs2_addr = t.r2; dec_rd_en = t.rde; dec_rd_addr = t.rd;
      dec_unit = t.un; iss_ready = t.ir; unit_busy = t.busy; wb_en = t.wbe;
      wb_rd_addr = t.wba; pipe_flush = t.fl;
      dec_payload = {8{$urandom()}};
      #3;
      check({tag, " dec_ready"},  dec_ready,  t.erdy);
      check({tag, " iss_valid"},  iss_valid,  t.eiv);
      check({tag, " sb_pending"}, sb_pending, t.esb);
      check({tag, " stall_cnt"},  stall_cnt,  exp_stall);
      if (iss_valid && (iss_ready || pipe_flush)) begin
         if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s sb_empty: issue register valid, expected none", tag);
         end else begin
            e = sbq.pop_front();
            if (iss_ready) begin
               check({tag, " iss_unit"},    iss_unit,    e.un);
               check({tag, " iss_rd_en"},   iss_rd_en,   e.rde);
               check({tag, " iss_rd_addr"}, iss_rd_addr, e.rd);
               check({tag, " iss_payload"}, iss_payload, e.pl);
            end
         end
      end
      if (t.v && t.erdy) sbq.push_back('{t.un, t.rde, t.rd, dec_payload});
      if (t.v && !t.erdy && !t.fl && exp_stall != 4'hf) exp_stall++;
      @(posedge clk); #1;
   endtask

   vec_t tbl[19];

   initial begin
      // v r1e r1 r2e r2 rde rd un ir busy wbe wba fl | rdy iv sb
      tbl[0]  = mk(1,0,0,0,0,1,5,1,0,0,0,0,0,               1,0,0);
      tbl[1]  = mk(1,1,5,0,0,1,6,0,0,0,0,0,0,               0,1,0);
      tbl[2]  = mk(1,1,5,0,0,1,6,0,1,0,0,0,0,               0,1,0);
      tbl[3]  = mk(1,1,5,0,0,1,6,0,1,0,0,0,0,               0,0,'h20);
      tbl[4]  = mk(1,1,5,0,0,1,6,0,0,0,4'b0010,{5'd0,5'd0,5'd5,5'd0},0, 1,0,'h20);
      tbl[5]  = mk(1,0,0,1,6,1,0,2,1,0,0,0,0,               0,1,0);
      tbl[6]  = mk(1,0,0,1,6,1,0,2,1,0,4'b0001,{15'd0,5'd6},0,  1,0,'h40);
      tbl[7]  = mk(1,1,0,1,0,1,3,3,1,0,0,0,0,               1,1,0);
      tbl[8]  = mk(1,0,0,0,0,1,3,0,0,0,0,0,0,               0,1,0);
      tbl[9]  = mk(1,0,0,0,0,1,3,0,1,0,0,0,0,               0,1,0);
      tbl[10] = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,               1,0,'h8);
      tbl[11] = mk(1,0,0,0,0,0,0,2,0,4'b0100,0,0,0,         0,0,'h8);
      tbl[12] = mk(1,0,0,0,0,0,9,2,0,0,0,0,0,               1,0,'h8);
      tbl[13] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,               0,1,'h8);
      tbl[14] = mk(1,1,9,0,0,0,0,1,0,0,0,0,0,               0,1,'h8);
      tbl[15] = mk(1,1,9,0,0,0,0,1,1,0,0,0,0,               1,1,'h8);
      tbl[16] = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,               1,1,'h8);
      tbl[17] = mk(0,0,0,0,0,0,0,0,0,0,4'b1100,{5'd3,5'd17,5'd0,5'd0},0, 1,0,'h8);
      tbl[18] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,               1,0,0);

      idle();
      rst_n = 0;
      #12;
      check("rst iss_valid", iss_valid, 1'b0);
      check("rst sb_pending", sb_pending, 32'd0);
      check("rst stall_cnt", stall_cnt, 4'd0);
      check("rst dec_ready", dec_ready, 1'b1);
      rst_n = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) cyc(tbl[i], $sformatf("vec%0d", i));

      // Same-cycle set and clear of r3: set wins.
      cyc(mk(1,0,0,0,0,1,3,0,0,0,0,0,0, 1,0,0), "col0");
      cyc(mk(0,0,0,0,0,0,0,0,1,0,0,0,0, 1,1,0), "col1");
      cyc(mk(1,0,0,0,0,1,3,1,0,0,4'b0001,{15'd0,5'd3},0, 1,0,'h8), "col2");
      cyc(mk(0,0,0,0,0,0,0,0,1,0,4'b0100,{5'd0,5'd3,10'd0},0, 1,1,0), "col3");
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,'h8), "col4");

      // Flush of a held rd=9: no scoreboard set, r3 retained.
      cyc(mk(1,0,0,0,0,1,9,0,0,0,0,0,0, 1,0,'h8), "fl0");
      cyc(mk(1,1,1,0,0,0,0,1,0,0,0,0,1, 0,1,'h8), "fl1");
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,'h8), "fl2");
      cyc(mk(0,0,0,0,0,0,0,0,0,0,4'b0010,{10'd0,5'd3,5'd0},0, 1,0,'h8), "fl3");

      // x0 destination then x0 source back-to-back.
      cyc(mk(1,0,0,0,0,1,0,0,0,0,0,0,0, 1,0,0), "x0a");
      cyc(mk(1,1,0,0,0,0,0,1,1,0,0,0,0, 1,1,0), "x0b");
      cyc(mk(0,0,0,0,0,0,0,0,1,0,0,0,0, 1,1,0), "x0c");
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0), "x0d");

      // Stall counter saturates at all-ones.
      for (int i = 0; i < 9; i++)
         cyc(mk(1,0,0,0,0,0,0,0,0,4'b0001,0,0,0, 0,0,0), $sformatf("sat%0d", i));
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0), "sat_end");
      check("stall_sat", stall_cnt, 4'hf);

      // Reset mid-operation drops the held instruction and pending bits.
      cyc(mk(1,0,0,0,0,1,5,0,0,0,0,0,0, 1,0,0), "rs0");
      cyc(mk(1,0,0,0,0,1,6,1,1,0,0,0,0, 1,1,0), "rs1");
      rst_n = 0;
      #1;
      check("midrst iss_valid", iss_valid, 1'b0);
      check("midrst sb_pending", sb_pending, 32'd0);
      check("midrst stall_cnt", stall_cnt, 4'd0);
      check("midrst iss_rd_addr", iss_rd_addr, 5'd0);
      check("midrst iss_payload", iss_payload, '0);
      sbq.delete();
      exp_stall = 4'd0;
      idle();
      #1;
      rst_n = 1;
      @(posedge clk); #1;
      cyc(mk(1,0,0,0,0,1,7,2,0,0,0,0,0, 1,0,0), "post0");
      cyc(mk(0,0,0,0,0,0,0,0,1,0,0,0,0, 1,1,0), "post1");
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,'h80), "post2");

      check("sb_drain", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1, "timeout");
   end

endmodule
